// File: rtl/matrix_transmitter.sv
// matrix_transmitter: UART-style serial sender for a 2x4 matrix of W-bit cells.
// Frame = start(0), N*W data bits (cell LSB first, row-major), optional parity, stop(1).
// Optional feature macro: TX_DONE_EN adds a one-clock `done` pulse at frame end.
module matrix_transmitter #(
  parameter int W   = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         row,
  input  logic [1:0]   col,
  input  logic         we,
  input  logic [W-1:0] din,
  input  logic         start,
  input  logic [3:0]   action,
  output logic         tx,
  output logic         busy,
  output logic [W-1:0] r_cell
`ifdef TX_DONE_EN
  ,
  output logic         done
`endif
);

  localparam int NB = 8 * W;
  localparam int CW = $clog2(NB);
  localparam int DW = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [1:0][3:0][W-1:0] mat;
  state_t                 state, state_nxt;
  logic [NB-1:0]          shreg, shreg_nxt, snap;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_load;
  logic [DW-1:0]          dcnt, dcnt_nxt;
  logic                   par, par_nxt;
  logic                   tx_nxt, busy_nxt;
  logic                   bit_end, accept, valid_act;
`ifdef TX_DONE_EN
  logic                   done_nxt;
`endif

  // Host write port; independent of the frame, which only sees the snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mat <= '0;
    else if (we) mat[row][col] <= din;
  end

  assign r_cell = mat[row][col];

  // Gather the selected cells into send order (first cell in the LSBs)
  always_comb begin
    snap      = '0;
    cnt_load  = '0;
    valid_act = 1'b1;
    case (action)
      4'd2: begin
        snap[W-1:0] = mat[row][col];
        cnt_load    = CW'(W - 1);
      end
      4'd3: begin
        snap[4*W-1:0] = mat[row];
        cnt_load      = CW'(4 * W - 1);
      end
      4'd4: begin
        snap[W-1:0]  = mat[0][col];
        snap[W +: W] = mat[1][col];
        cnt_load     = CW'(2 * W - 1);
      end
      4'd5: begin
        snap     = mat;
        cnt_load = CW'(NB - 1);
      end
      default: valid_act = 1'b0;
    endcase
  end

  assign bit_end = (dcnt == DW'(DIV - 1));
  assign accept  = (state == IDLE) && start && valid_act;

  // Next-state and next-output logic; tx changes only on bit boundaries
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    busy_nxt  = busy;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par;
    dcnt_nxt  = bit_end ? '0 : dcnt + 1'b1;
`ifdef TX_DONE_EN
    done_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        dcnt_nxt = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (accept) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          shreg_nxt = snap;
          cnt_nxt   = cnt_load;
          par_nxt   = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_nxt = DATA;
        tx_nxt    = shreg[0];
        par_nxt   = par ^ shreg[0];
        shreg_nxt = shreg >> 1;
      end
      DATA: if (bit_end) begin
        if (cnt == '0) begin
          if (PAR != 0) begin
            state_nxt = PARITY;
            tx_nxt    = (PAR == 2) ? ~par : par;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          tx_nxt    = shreg[0];
          par_nxt   = par ^ shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = cnt - 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
`ifdef TX_DONE_EN
        done_nxt  = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs; reset aborts any frame immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx    <= 1'b1;
      busy  <= 1'b0;
      shreg <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      par   <= 1'b0;
    end else begin
      tx    <= tx_nxt;
      busy  <= busy_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      dcnt  <= dcnt_nxt;
      par   <= par_nxt;
    end
  end

`ifdef TX_DONE_EN
  // End-of-frame pulse, only after a complete stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= done_nxt;
  end
`endif

endmodule

// File: tb/tb_matrix_transmitter.sv
// Directed bench for matrix_transmitter: u_a (DIV=3, even parity), u_b (DIV=4, no parity).
module tb_matrix_transmitter;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       row = 1'b0, we = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [1:0] col = 2'd0;
  logic [7:0] din = 8'h00;
  logic [3:0] action = 4'd0;
  logic       tx_a, busy_a, tx_b, busy_b;
  logic [7:0] rc_a, rc_b;
`ifdef TX_DONE_EN
  logic       done_a, done_b;
`endif

  int errs = 0, checks = 0;
  logic [599:0] txs;
  int blen;

  always #5 clk = ~clk;

  matrix_transmitter #(.W(8), .DIV(3), .PAR(1)) u_a (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .we(we), .din(din),
    .start(start_a), .action(action), .tx(tx_a), .busy(busy_a), .r_cell(rc_a)
`ifdef TX_DONE_EN
    , .done(done_a)
`endif
  );

  matrix_transmitter #(.W(8), .DIV(4), .PAR(0)) u_b (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .we(1'b0), .din(8'h00),
    .start(start_b), .action(action), .tx(tx_b), .busy(busy_b), .r_cell(rc_b)
`ifdef TX_DONE_EN
    , .done(done_b)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic r, input logic [1:0] c, input logic [7:0] d);
    we = 1'b1; row = r; col = c; din = d;
    tick();
    we = 1'b0;
  endtask

  // Start a frame on u_a and record tx for every cycle busy is high
  task automatic send(input logic [3:0] act, input logic r, input logic [1:0] c);
    start_a = 1'b1; action = act; row = r; col = c;
    tick();
    start_a = 1'b0; we = 1'b0;
    blen = 0; txs = '1;
    while (busy_a && blen < 600) begin
      txs[blen] = tx_a;
      blen++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (tx_a !== 1'b1)   begin errs++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (rc_a !== 8'h00)  begin errs++; $display("FAIL reset_rcell got=%h exp=00", rc_a); end
    checks++; if ({busy_b, tx_b} !== 2'b01) begin errs++; $display("FAIL reset_b got=%b exp=01", {busy_b, tx_b}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cell();
    logic [127:0] fr;
    wr(1'b0, 2'd1, 8'hA5);
    checks++; if (rc_a !== 8'hA5) begin errs++; $display("FAIL cell_rcell got=%h exp=a5", rc_a); end
    send(4'd2, 1'b0, 2'd1);
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    checks++; if (blen !== 33) begin errs++; $display("FAIL cell_len got=%0d exp=33", blen); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL cell_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
    checks++; if (tx_a !== 1'b1) begin errs++; $display("FAIL cell_idle_tx got=%b exp=1", tx_a); end
  endtask

  task automatic test_row();
    logic [127:0] fr;
    wr(1'b1, 2'd0, 8'h01); wr(1'b1, 2'd1, 8'h02);
    wr(1'b1, 2'd2, 8'h03); wr(1'b1, 2'd3, 8'h04);
    send(4'd3, 1'b1, 2'd0);
    fr = {1'b1, 1'b1, 32'h04030201, 1'b0};
    checks++; if (blen !== 105) begin errs++; $display("FAIL row_len got=%0d exp=105", blen); end
    for (int i = 0; i < 35; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL row_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
  endtask

  task automatic test_column();
    logic [127:0] fr;
    wr(1'b0, 2'd2, 8'h11); wr(1'b1, 2'd2, 8'h22);
    fork
      send(4'd4, 1'b0, 2'd2);
      begin
        repeat (12) @(posedge clk);
        #1; we = 1'b1; row = 1'b1; col = 2'd2; din = 8'hFF;
        tick(); we = 1'b0;
      end
    join
    fr = {1'b1, 1'b0, 16'h2211, 1'b0};
    checks++; if (blen !== 57) begin errs++; $display("FAIL col_len got=%0d exp=57", blen); end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL col_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
    row = 1'b1; col = 2'd2; #1;
    checks++; if (rc_a !== 8'hFF) begin errs++; $display("FAIL col_rcell got=%h exp=ff", rc_a); end
  endtask

  task automatic test_ignore();
    logic [3:0] bad [2];
    bad[0] = 4'd7; bad[1] = 4'd0;
    for (int k = 0; k < 2; k++) begin
      action = bad[k]; start_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        checks++;
        if ({busy_a, tx_a} !== 2'b01) begin errs++; $display("FAIL ignore_act%0d got=%b exp=01", bad[k], {busy_a, tx_a}); end
      end
      start_a = 1'b0;
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] fr;
    fork
      send(4'd2, 1'b0, 2'd1);
      begin
        repeat (8) @(posedge clk);
        #1; start_a = 1'b1; action = 4'd5;
        tick(); start_a = 1'b0;
      end
    join
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    checks++; if (blen !== 33) begin errs++; $display("FAIL busy_start_len got=%0d exp=33", blen); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL busy_start_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
    tick();
    checks++; if ({busy_a, tx_a} !== 2'b01) begin errs++; $display("FAIL busy_start_after got=%b exp=01", {busy_a, tx_a}); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] fr;
    wr(1'b0, 2'd3, 8'h3C);
    we = 1'b1; din = 8'hC3;             // write lands in the accept cycle
    send(4'd2, 1'b0, 2'd3);
    fr = {1'b1, 1'b0, 8'h3C, 1'b0};
    checks++; if (blen !== 33) begin errs++; $display("FAIL b2b_len1 got=%0d exp=33", blen); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL b2b_f1_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
    checks++; if (tx_a !== 1'b1) begin errs++; $display("FAIL b2b_gap_tx got=%b exp=1", tx_a); end
    send(4'd2, 1'b0, 2'd3);
    fr = {1'b1, 1'b0, 8'hC3, 1'b0};
    checks++; if (blen !== 33) begin errs++; $display("FAIL b2b_len2 got=%0d exp=33", blen); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL b2b_f2_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] fr;
    start_a = 1'b1; action = 4'd3; row = 1'b1; col = 2'd0;
    tick();
    start_a = 1'b0;
    repeat (15) tick();
    checks++; if (busy_a !== 1'b1) begin errs++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy_a); end
    rst_n = 1'b0;
    #2;
    checks++; if (tx_a !== 1'b1)   begin errs++; $display("FAIL rstmid_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    checks++; if (rc_a !== 8'h00)  begin errs++; $display("FAIL rstmid_rcell got=%h exp=00", rc_a); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if ({busy_a, tx_a} !== 2'b01) begin errs++; $display("FAIL rstmid_idle got=%b exp=01", {busy_a, tx_a}); end
    wr(1'b0, 2'd0, 8'h5B);
    send(4'd2, 1'b0, 2'd0);
    fr = {1'b1, 1'b1, 8'h5B, 1'b0};
    checks++; if (blen !== 33) begin errs++; $display("FAIL rstmid_len got=%0d exp=33", blen); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (txs[i*3 +: 3] !== {3{fr[i]}}) begin errs++; $display("FAIL rstmid_bit%0d got=%b exp=%b", i, txs[i*3 +: 3], {3{fr[i]}}); end
    end
  endtask

  task automatic test_whole_matrix();
    int n, dn;
    start_b = 1'b1; action = 4'd5;
    tick();
    start_b = 1'b0;
    n = 0; dn = 0; txs = '1;
    while (busy_b && n < 600) begin
      txs[n] = tx_b;
`ifdef TX_DONE_EN
      if (done_b) dn++;
`endif
      n++;
      tick();
    end
    checks++; if (n !== 264) begin errs++; $display("FAIL whole_len got=%0d exp=264", n); end
    checks++; if (txs[259:0] !== 260'd0) begin errs++; $display("FAIL whole_low ones_seen=%0d exp=0", $countones(txs[259:0])); end
    checks++; if (txs[263:260] !== 4'hF) begin errs++; $display("FAIL whole_stop got=%b exp=1111", txs[263:260]); end
    checks++; if (tx_b !== 1'b1) begin errs++; $display("FAIL whole_idle_tx got=%b exp=1", tx_b); end
`ifdef TX_DONE_EN
    checks++; if (dn !== 0)        begin errs++; $display("FAIL whole_done_early got=%0d exp=0", dn); end
    checks++; if (done_b !== 1'b1) begin errs++; $display("FAIL whole_done_pulse got=%b exp=1", done_b); end
    tick();
    checks++; if (done_b !== 1'b0) begin errs++; $display("FAIL whole_done_clear got=%b exp=0", done_b); end
`endif
  endtask

  initial begin
    test_reset();
    test_cell();
    test_row();
    test_column();
    test_ignore();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_whole_matrix();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/matrix_transmitter.md
# matrix_transmitter

Serial UART-style transmitter for the 2×4 matrix of W-bit cells, the sending end of the matrix receiver link. A host loads cells through a write port, then starts a transfer of one cell, one row, one column or the whole matrix. The block emits one frame: a start bit, the selected cells' data bits, optional parity, and a stop bit. The frame format, bit period and parity rule match the receiver, so the two blocks connect tx→rx directly.

## Interface
- W, 8, cell width in bits
- DIV, 3, clocks per bit period (≥2)
- PAR, 0, parity mode: 0 none, 1 even (parity bit = XOR of all data bits), 2 odd (inverted XOR)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- row  in  1  row select for write, read and transfer
- col  in  2  column select for write, read and transfer
- we  in  1  write din into matrix[row][col]
- din  in  W  write data
- start  in  1  transfer request, sampled while idle
- action  in  4  transfer kind: 2 cell, 3 row, 4 column, 5 whole matrix
- tx  out  1  serial line, idles high
- busy  out  1  frame in progress
- r_cell  out  W  combinational read of matrix[row][col]

## Operation
- Reset (async, rst_n=0): matrix all zero, tx=1, busy=0, snapshot and counters cleared. Reset mid-frame aborts the frame at once; no stop bit is sent.
- The write port is always enabled, including while busy. A write changes the matrix only, never an in-flight frame.
- Accept: when busy=0, start=1 and action ∈ {2,3,4,5}. Other action codes, or start while busy, are ignored without side effects.
- On accept: copy the selected cells into a snapshot, in send order, and latch the cell count N (1/4/2/8). If a write occurs in the accept cycle, the snapshot holds the pre-write values.
- Send order is row-major: row 0 before row 1, ascending column within a row. Action 3 sends row `row`, cols 0..3. Action 4 sends col `col`, rows 0,1.
- FSM states:
  - IDLE: tx=1. On accept, go to START.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: send N×W bits, each cell LSB first, with no gaps between cells.
  - After DATA: go to PARITY if PAR≠0, otherwise go to STOP.
  - PARITY: one bit computed over all N×W data bits.
  - STOP: tx=1 for one bit period, then go to IDLE.
- Parity accumulates serially as the data bits are shifted out.

## Timing
- On an accept in cycle t, busy=1 and tx=0 are registered at edge t+1.
- Each bit holds tx steady for exactly DIV clocks.
- Frame length = DIV·(2 + N·W + P) clocks, where P=1 if PAR≠0 and 0 otherwise.
- busy falls on the same edge the STOP period ends. tx stays 1.
- The earliest next accept is the cycle after busy falls, so back-to-back frames have zero idle bits.
- tx and busy are registered outputs and glitch-free. r_cell is combinational.

## Configuration
- TX_DONE_EN defined: adds output `done` (1 bit, reset 0). `done` pulses high for exactly one clock on the edge where busy falls after a complete stop bit. It does not pulse on reset abort.
- TX_DONE_EN undefined: no `done` port and no related logic.

## Test plan
- W=8, DIV=3, PAR=1: write [0][1]=0xA5, then start with action=2, row=0, col=1.
  - tx is 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1. Each bit lasts 3 clocks.
  - busy is high for 33 clocks.
- Same configuration: row 1 = 0x01,0x02,0x03,0x04, start with action=3, row=1.
  - 32 data bits, LSB first, cell order col 0..3.
  - Parity = 1 (five ones). busy is high for 105 clocks.
- Action 4, col=2, with [0][2]=0x11 and [1][2]=0x22. Mid-frame, write [1][2]=0xFF.
  - Frame carries 0x11 then 0x22.
  - r_cell at row 1, col 2 reads 0xFF after the write.
- start with action=7 or action=0 while idle: busy stays 0 and tx stays 1 throughout. start pulsed while busy: the frame is unchanged.
- Drive rst_n low during DATA: tx=1 and busy=0 asynchronously, and r_cell reads 0.
  - After release, a new action=2 frame is sent correctly.
- W=8, DIV=4, PAR=0, matrix all zero, action=5:
  - tx low for 65 bit periods (260 clocks), then high for 4 clocks.
  - busy is high for 264 clocks. With TX_DONE_EN, `done` pulses once at the end.
